// File: rtl/atm_ledger_arbiter.sv
// ---------------------------------------------------------------------------
// atm_ledger_arbiter
//   Shared balance ledger for N_TERM ATM terminals. A round-robin arbiter
//   picks one pending request. The request then runs through a fixed
//   IDLE -> LOAD -> EXEC -> RESP sequence, so every balance update is atomic.
//
//   Optional feature macro: ATM_WD_LIMIT_EN
//     When defined, WDR and XFR with amount > WD_LIMIT are rejected.
//     When undefined, there is no per-transaction cap and WD_LIMIT is unused.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   req         in   per-terminal request level            [N_TERM]
//   op          in   per-terminal opcode 00 BAL 01 WDR 10 DEP 11 XFR
//   src_idx     in   per-terminal source account           [IDX_W*N_TERM]
//   dst_idx     in   per-terminal destination (XFR only)   [IDX_W*N_TERM]
//   amount      in   per-terminal amount                   [AMT_W*N_TERM]
//   gnt         out  one-hot grant, high from LOAD through RESP
//   done        out  one-cycle completion strobe (state RESP)
//   err         out  rejection flag, valid with done
//   result_bal  out  source balance after the operation, valid with done
//   busy        out  high whenever state != IDLE
//   state_dbg   out  current FSM state, for checkers and debug
//
// Handshake: a terminal raises req with stable operands and keeps them
// stable until it sees done while its gnt bit is set. The operands are
// latched at grant time, so dropping req after the grant does not cancel the
// transaction. A req still high after done counts as a new request.
// ---------------------------------------------------------------------------
module atm_ledger_arbiter #(
   parameter int N_TERM   = 4,
   parameter int N_ACC    = 10,
   parameter int IDX_W    = 4,
   parameter int BAL_W    = 16,
   parameter int AMT_W    = 11,
   parameter int INIT_BAL = 500,
   parameter int WD_LIMIT = 1000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_TERM-1:0]         req,
   input  logic [2*N_TERM-1:0]       op,
   input  logic [IDX_W*N_TERM-1:0]   src_idx,
   input  logic [IDX_W*N_TERM-1:0]   dst_idx,
   input  logic [AMT_W*N_TERM-1:0]   amount,
   output logic [N_TERM-1:0]         gnt,
   output logic                      done,
   output logic                      err,
   output logic [BAL_W-1:0]          result_bal,
   output logic                      busy,
   output logic [1:0]                state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_EXEC = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam logic [1:0] OP_BAL = 2'b00;
   localparam logic [1:0] OP_WDR = 2'b01;
   localparam logic [1:0] OP_DEP = 2'b10;
   localparam logic [1:0] OP_XFR = 2'b11;

   localparam int               PTR_W   = (N_TERM > 1) ? $clog2(N_TERM) : 1;
   localparam logic [IDX_W:0]   N_ACC_V = (IDX_W+1)'(N_ACC);
   localparam logic [BAL_W-1:0] INIT_V  = BAL_W'(INIT_BAL);
`ifdef ATM_WD_LIMIT_EN
   localparam logic [AMT_W:0]   LIMIT_V = (AMT_W+1)'(WD_LIMIT);
`endif

   state_t             state, state_nx;
   logic [PTR_W-1:0]   ptr;
   logic [BAL_W-1:0]   ledger [N_ACC];

   // Operands latched at grant time.
   logic [1:0]         lat_op;
   logic [IDX_W-1:0]   lat_src, lat_dst;
   logic [AMT_W-1:0]   lat_amt;
   // Working copies of the two balances, read in LOAD.
   logic [BAL_W-1:0]   bal_s, bal_d;

   // ---------------- round-robin winner search ----------------
   logic               any_req;
   logic [PTR_W-1:0]   win;
   int                 cand;

   always_comb begin
      any_req = 1'b0;
      win     = ptr;
      cand    = 0;
      // Search starts one past the last winner, so every active requester
      // is reached within N_TERM grants.
      for (int k = 1; k <= N_TERM; k++) begin
         cand = (int'(ptr) + k) % N_TERM;
         if (!any_req && req[cand]) begin
            any_req = 1'b1;
            win     = PTR_W'(cand);
         end
      end
   end

   // ---------------- FSM next state and status outputs ----------------
   always_comb begin
      state_nx  = state;
      done      = 1'b0;
      busy      = 1'b1;
      state_dbg = state;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (any_req) state_nx = S_LOAD;
         end
         S_LOAD: state_nx = S_EXEC;
         S_EXEC: state_nx = S_RESP;
         S_RESP: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // ---------------- checks and new balances ----------------
   logic               src_ok, dst_ok, over_lim;
   logic [BAL_W-1:0]   amt_ext;
   logic [BAL_W:0]     sum_s, sum_d;    // one extra bit catches overflow
   logic               x_err;
   logic [BAL_W-1:0]   x_res, x_new_src, x_new_dst;

   always_comb begin
      src_ok  = {1'b0, lat_src} < N_ACC_V;
      dst_ok  = {1'b0, lat_dst} < N_ACC_V;
      amt_ext = BAL_W'(lat_amt);
      sum_s   = {1'b0, bal_s} + {1'b0, amt_ext};
      sum_d   = {1'b0, bal_d} + {1'b0, amt_ext};
`ifdef ATM_WD_LIMIT_EN
      over_lim = {1'b0, lat_amt} > LIMIT_V;
`else
      over_lim = 1'b0;
`endif
      x_err     = 1'b0;
      x_new_src = bal_s;
      x_new_dst = bal_d;
      case (lat_op)
         OP_WDR: begin
            x_err     = (amt_ext > bal_s) || over_lim;
            x_new_src = bal_s - amt_ext;
         end
         OP_DEP: begin
            x_err     = sum_s[BAL_W];
            x_new_src = sum_s[BAL_W-1:0];
         end
         OP_XFR: begin
            x_err     = !dst_ok || (lat_dst == lat_src) || (amt_ext > bal_s) ||
                        sum_d[BAL_W] || over_lim;
            x_new_src = bal_s - amt_ext;
            x_new_dst = sum_d[BAL_W-1:0];
         end
         default: x_err = 1'b0;       // BAL
      endcase
      if (!src_ok) x_err = 1'b1;
      // Invalid source reports 0; any other rejection reports the old balance.
      if (!src_ok)    x_res = '0;
      else if (x_err) x_res = bal_s;
      else            x_res = x_new_src;
   end

   // ---------------- state, operands and ledger ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ptr        <= PTR_W'(N_TERM - 1);
         gnt        <= '0;
         err        <= 1'b0;
         result_bal <= '0;
         lat_op     <= OP_BAL;
         lat_src    <= '0;
         lat_dst    <= '0;
         lat_amt    <= '0;
         bal_s      <= '0;
         bal_d      <= '0;
         for (int a = 0; a < N_ACC; a++) ledger[a] <= INIT_V;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: if (any_req) begin
               ptr     <= win;
               gnt     <= N_TERM'(1) << win;
               lat_op  <= op[2*int'(win) +: 2];
               lat_src <= src_idx[IDX_W*int'(win) +: IDX_W];
               lat_dst <= dst_idx[IDX_W*int'(win) +: IDX_W];
               lat_amt <= amount[AMT_W*int'(win) +: AMT_W];
            end
            S_LOAD: begin
               // Out-of-range indices read as 0; EXEC rejects them anyway.
               bal_s <= '0;
               bal_d <= '0;
               for (int a = 0; a < N_ACC; a++) begin
                  if (lat_src == IDX_W'(a)) bal_s <= ledger[a];
                  if (lat_dst == IDX_W'(a)) bal_d <= ledger[a];
               end
            end
            S_EXEC: begin
               err        <= x_err;
               result_bal <= x_res;
               if (!x_err) begin
                  for (int a = 0; a < N_ACC; a++) begin
                     if (lat_op != OP_BAL && lat_src == IDX_W'(a)) ledger[a] <= x_new_src;
                     if (lat_op == OP_XFR && lat_dst == IDX_W'(a)) ledger[a] <= x_new_dst;
                  end
               end
            end
            S_RESP: gnt <= '0;
            default: gnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
module tb_atm_ledger_arbiter;

   localparam int N_TERM = 4;
   localparam int IDX_W  = 4;
   localparam int BAL_W  = 16;
   localparam int AMT_W  = 11;

   localparam logic [1:0] BAL = 2'b00;
   localparam logic [1:0] WDR = 2'b01;
   localparam logic [1:0] DEP = 2'b10;
   localparam logic [1:0] XFR = 2'b11;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N_TERM-1:0]       req;
   logic [2*N_TERM-1:0]     op;
   logic [IDX_W*N_TERM-1:0] src_idx, dst_idx;
   logic [AMT_W*N_TERM-1:0] amount;

   logic [N_TERM-1:0] gnt, gnt_hi;
   logic              done, done_hi, err, err_hi, busy, busy_hi;
   logic [BAL_W-1:0]  result_bal, result_bal_hi;
   logic [1:0]        state_dbg, state_dbg_hi;

   atm_ledger_arbiter u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .src_idx(src_idx),
      .dst_idx(dst_idx), .amount(amount), .gnt(gnt), .done(done), .err(err),
      .result_bal(result_bal), .busy(busy), .state_dbg(state_dbg)
   );

   atm_ledger_arbiter #(.INIT_BAL(65000)) u_dut_hi (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .src_idx(src_idx),
      .dst_idx(dst_idx), .amount(amount), .gnt(gnt_hi), .done(done_hi), .err(err_hi),
      .result_bal(result_bal_hi), .busy(busy_hi), .state_dbg(state_dbg_hi)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [N_TERM-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_term(input int t, input logic [1:0] o, input int s, input int d, input int a);
      op[2*t +: 2]              = o;
      src_idx[IDX_W*t +: IDX_W] = IDX_W'(s);
      dst_idx[IDX_W*t +: IDX_W] = IDX_W'(d);
      amount[AMT_W*t +: AMT_W]  = AMT_W'(a);
   endtask

   // One full transaction from terminal t, checked for latency, grant,
   // err and result_bal; optionally also checks the INIT_BAL=65000 copy.
   task automatic do_txn(input string tag, input int t, input logic [1:0] o,
                         input int s, input int d, input int a,
                         input logic e_err, input int e_bal,
                         input logic chk_hi, input logic e_err_hi, input int e_bal_hi);
      int n;
      logic [N_TERM-1:0] g_first, g_exp;
      @(negedge clk);
      set_term(t, o, s, d, a);
      req[t]  = 1'b1;
      g_exp   = N_TERM'(1) << t;
      g_first = '0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) g_first = gnt;
      end while (!done && n < 12);
      check({tag, "_latency"}, 32'(n), 32'd3);
      check({tag, "_gnt_load"}, 32'(g_first), 32'(g_exp));
      check({tag, "_gnt_resp"}, 32'(gnt), 32'(g_exp));
      check({tag, "_err"}, 32'(err), 32'(e_err));
      check({tag, "_bal"}, 32'(result_bal), 32'(e_bal));
      if (chk_hi) begin
         check({tag, "_hi_err"}, 32'(err_hi), 32'(e_err_hi));
         check({tag, "_hi_bal"}, 32'(result_bal_hi), 32'(e_bal_hi));
      end
      req[t] = 1'b0;
      @(negedge clk);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 12);
      check({tag, "_done"}, 32'(done), 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   logic [N_TERM-1:0] exp_g;

   initial begin
      rst_n   = 1'b0;
      req     = '0;
      op      = '0;
      src_idx = '0;
      dst_idx = '0;
      amount  = '0;

      // 1. reset state and first BAL
      do_reset();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_bal", 32'(result_bal), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      do_txn("t0_bal3", 0, BAL, 3, 0, 0, 1'b0, 500, 1'b0, 1'b0, 0);

      // 2. withdraw then read back
      do_txn("t1_wdr200", 1, WDR, 1, 0, 200, 1'b0, 300, 1'b0, 1'b0, 0);
      do_txn("t1_bal1", 1, BAL, 1, 0, 0, 1'b0, 300, 1'b0, 1'b0, 0);

      // 3. insufficient funds, invalid source
      do_txn("t2_wdr600", 2, WDR, 2, 0, 600, 1'b1, 500, 1'b0, 1'b0, 0);
      do_txn("t2_bal2", 2, BAL, 2, 0, 0, 1'b0, 500, 1'b0, 1'b0, 0);
      do_txn("t2_bal12", 2, BAL, 12, 0, 0, 1'b1, 0, 1'b0, 1'b0, 0);

      // 4. transfers
      do_txn("t0_xfr0_9", 0, XFR, 0, 9, 100, 1'b0, 400, 1'b0, 1'b0, 0);
      do_txn("t0_bal9", 0, BAL, 9, 0, 0, 1'b0, 600, 1'b0, 1'b0, 0);
      do_txn("t0_xfr0_0", 0, XFR, 0, 0, 50, 1'b1, 400, 1'b0, 1'b0, 0);
      do_txn("t0_xfr0_10", 0, XFR, 0, 10, 50, 1'b1, 400, 1'b0, 1'b0, 0);
      do_txn("t3_dep0amt", 3, DEP, 5, 0, 0, 1'b0, 500, 1'b0, 1'b0, 0);
      do_txn("t3_xfr9_1", 3, XFR, 9, 1, 600, 1'b0, 0, 1'b0, 1'b0, 0);
      do_txn("t3_bal1", 3, BAL, 1, 0, 0, 1'b0, 900, 1'b0, 1'b0, 0);
      do_txn("t1_wdr901", 1, WDR, 1, 0, 901, 1'b1, 900, 1'b0, 1'b0, 0);

      // 5. round-robin fairness
      do_reset();
      @(negedge clk);
      set_term(0, BAL, 0, 0, 0);
      set_term(1, BAL, 1, 0, 0);
      set_term(2, BAL, 2, 0, 0);
      req = 4'b0101;
      exp_q = {4'b0001, 4'b0100, 4'b0001, 4'b0100,
               4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
      for (int i = 0; i < 10; i++) begin
         wait_done("rr");
         exp_g = exp_q.pop_front();
         check("rr_gnt", 32'(gnt), 32'(exp_g));
         check("rr_err", 32'(err), 32'd0);
         if (i == 3) req[1] = 1'b1;
      end
      req = '0;
      repeat (2) @(negedge clk);

      // reset in the middle of a transfer
      @(negedge clk);
      set_term(0, XFR, 0, 9, 100);
      req[0] = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_state_exec", 32'(state_dbg), 32'd2);
      rst_n  = 1'b0;
      req[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_gnt", 32'(gnt), 32'd0);
      do_txn("mid_bal0", 0, BAL, 0, 0, 0, 1'b0, 500, 1'b0, 1'b0, 0);
      do_txn("mid_bal9", 0, BAL, 9, 0, 0, 1'b0, 500, 1'b0, 1'b0, 0);

      // 6. overflow on deposit, optional debit cap
      do_reset();
      do_txn("dep600", 0, DEP, 0, 0, 600, 1'b0, 1100, 1'b1, 1'b1, 65000);
`ifdef ATM_WD_LIMIT_EN
      do_txn("wdr1001", 0, WDR, 0, 0, 1001, 1'b1, 1100, 1'b1, 1'b1, 65000);
`else
      do_txn("wdr1001", 0, WDR, 0, 0, 1001, 1'b0, 99, 1'b1, 1'b0, 63999);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
